umi_demux_pipe: RTL and testbench



---
 rtl/umi_demux_pipe_pkg.sv | 28 ++
 rtl/umi_demux_fifo.sv | 55 +++++
 rtl/umi_demux_pipe.sv | 102 ++++++++++
 tb/tb_umi_demux_pipe.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/umi_demux_pipe_pkg.sv
// Shared types and helpers for the registered UMI demultiplexer.
package umi_demux_pipe_pkg;

    localparam int MAX_M = 32;
    localparam int IDXW  = 5;

    typedef struct packed {
        logic            ok;
        logic [IDXW-1:0] idx;
    } sel_dec_t;

    // ok only when exactly one select bit is set; idx is that bit's position
    function automatic sel_dec_t onehot_valid(input logic [MAX_M-1:0] sel);
        sel_dec_t r;
        int       n;
        r = '0;
        n = 0;
        for (int i = 0; i < MAX_M; i++) begin
            if (sel[i]) begin
                n++;
                r.idx = IDXW'(i);
            end
        end
        r.ok = (n == 1);
        return r;
    endfunction

endpackage

// File: rtl/umi_demux_fifo.sv
// Single-clock DEPTH-entry valid/ready FIFO with registered storage and full/empty flags.
module umi_demux_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         nreset,
    input  logic         push,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         valid,
    output logic [W-1:0] dout,
    input  logic         ready
);

    localparam int PW = $clog2(DEPTH);

    logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]             cnt_q, cnt_d;
    logic                    do_push, do_pop;

    assign full    = (cnt_q == (PW+1)'(DEPTH));
    assign valid   = (cnt_q != '0);
    assign dout    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = valid && ready;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
        cnt_d = cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/umi_demux_pipe.sv
// Registered 1:M UMI demux, one FIFO per output, select decoded from dstaddr[SELLSB+:M].
// Define UMI_DEMUX_PIPE_ERRCNT_EN to add the saturating err_count drop counter.
module umi_demux_pipe
    import umi_demux_pipe_pkg::*;
#(
    parameter int M      = 4,
    parameter int DW     = 256,
    parameter int CW     = 32,
    parameter int AW     = 64,
    parameter int DEPTH  = 2,
    parameter int SELLSB = 40
) (
    input  logic            clk,
    input  logic            nreset,
    input  logic            umi_in_valid,
    input  logic [CW-1:0]   umi_in_cmd,
    input  logic [AW-1:0]   umi_in_dstaddr,
    input  logic [AW-1:0]   umi_in_srcaddr,
    input  logic [DW-1:0]   umi_in_data,
    output logic            umi_in_ready,
    output logic [M-1:0]    umi_out_valid,
    output logic [M*CW-1:0] umi_out_cmd,
    output logic [M*AW-1:0] umi_out_dstaddr,
    output logic [M*AW-1:0] umi_out_srcaddr,
    output logic [M*DW-1:0] umi_out_data,
    input  logic [M-1:0]    umi_out_ready,
    output logic            err_drop
`ifdef UMI_DEMUX_PIPE_ERRCNT_EN
    ,
    output logic [15:0]     err_count
`endif
);

    typedef struct packed {
        logic [CW-1:0] cmd;
        logic [AW-1:0] dstaddr;
        logic [AW-1:0] srcaddr;
        logic [DW-1:0] data;
    } pkt_t;

    pkt_t           pkt_in;
    pkt_t [M-1:0]   pkt_out;
    logic [M-1:0]   full, push;
    sel_dec_t       dec;
    logic           tgt_full;
    logic           err_drop_d, err_drop_q;

    assign pkt_in = '{cmd: umi_in_cmd, dstaddr: umi_in_dstaddr,
                      srcaddr: umi_in_srcaddr, data: umi_in_data};

    // Ready uses only the registered full flags, never umi_out_ready
    always_comb begin
        dec      = onehot_valid(MAX_M'(umi_in_dstaddr[SELLSB+:M]));
        tgt_full = 1'b0;
        push     = '0;
        for (int i = 0; i < M; i++) begin
            if (dec.idx == IDXW'(i)) tgt_full = full[i];
            push[i] = umi_in_valid && dec.ok && (dec.idx == IDXW'(i)) && !full[i];
        end
        umi_in_ready = !umi_in_valid || !dec.ok || !tgt_full;
        err_drop_d   = umi_in_valid && !dec.ok;
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) err_drop_q <= 1'b0;
        else         err_drop_q <= err_drop_d;
    end
    assign err_drop = err_drop_q;

    for (genvar i = 0; i < M; i++) begin : g_port
        umi_demux_fifo #(.W($bits(pkt_t)), .DEPTH(DEPTH)) u_fifo (
            .clk    (clk),
            .nreset (nreset),
            .push   (push[i]),
            .din    (pkt_in),
            .full   (full[i]),
            .valid  (umi_out_valid[i]),
            .dout   (pkt_out[i]),
            .ready  (umi_out_ready[i])
        );
        assign umi_out_cmd[i*CW+:CW]     = pkt_out[i].cmd;
        assign umi_out_dstaddr[i*AW+:AW] = pkt_out[i].dstaddr;
        assign umi_out_srcaddr[i*AW+:AW] = pkt_out[i].srcaddr;
        assign umi_out_data[i*DW+:DW]    = pkt_out[i].data;
    end

`ifdef UMI_DEMUX_PIPE_ERRCNT_EN
    logic [15:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_drop_q && err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) err_cnt_q <= '0;
        else         err_cnt_q <= err_cnt_d;
    end
    assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_umi_demux_pipe.sv
// Randomized bench for umi_demux_pipe against a per-port queue model.
module tb_umi_demux_pipe;

    localparam int M = 4, DW = 256, CW = 32, AW = 64, DEPTH = 2, SELLSB = 40;
    localparam int PW = CW + 2*AW + DW;

    logic            clk = 1'b0;
    logic            nreset = 1'b0;
    logic            umi_in_valid = 1'b0;
    logic [CW-1:0]   umi_in_cmd = '0;
    logic [AW-1:0]   umi_in_dstaddr = '0;
    logic [AW-1:0]   umi_in_srcaddr = '0;
    logic [DW-1:0]   umi_in_data = '0;
    logic            umi_in_ready;
    logic [M-1:0]    umi_out_valid;
    logic [M*CW-1:0] umi_out_cmd;
    logic [M*AW-1:0] umi_out_dstaddr;
    logic [M*AW-1:0] umi_out_srcaddr;
    logic [M*DW-1:0] umi_out_data;
    logic [M-1:0]    umi_out_ready = '1;
    logic            err_drop;
`ifdef UMI_DEMUX_PIPE_ERRCNT_EN
    logic [15:0]     err_count;
`endif

    always #5 clk = ~clk;

    umi_demux_pipe #(.M(M), .DW(DW), .CW(CW), .AW(AW), .DEPTH(DEPTH), .SELLSB(SELLSB)) dut (
        .clk(clk), .nreset(nreset),
        .umi_in_valid(umi_in_valid), .umi_in_cmd(umi_in_cmd),
        .umi_in_dstaddr(umi_in_dstaddr), .umi_in_srcaddr(umi_in_srcaddr),
        .umi_in_data(umi_in_data), .umi_in_ready(umi_in_ready),
        .umi_out_valid(umi_out_valid), .umi_out_cmd(umi_out_cmd),
        .umi_out_dstaddr(umi_out_dstaddr), .umi_out_srcaddr(umi_out_srcaddr),
        .umi_out_data(umi_out_data), .umi_out_ready(umi_out_ready),
        .err_drop(err_drop)
`ifdef UMI_DEMUX_PIPE_ERRCNT_EN
        , .err_count(err_count)
`endif
    );

    // Model: one queue of whole packets per port, plus the pending drop flag and drop count
    logic [PW-1:0] mq [M][$];
    logic          exp_err = 1'b0;
    int            exp_cnt = 0;
    logic          last_acc = 1'b0;
    int            n_cmp = 0, n_bad = 0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int tgt_of(input logic [AW-1:0] d);
        logic [M-1:0] s;
        s = d[SELLSB+:M];
        if ($countones(s) != 1) return -1;
        for (int i = 0; i < M; i++) if (s[i]) return i;
        return -1;
    endfunction

    function automatic logic exp_ready();
        int t;
        t = tgt_of(umi_in_dstaddr);
        return !umi_in_valid || t < 0 || mq[t].size() < DEPTH;
    endfunction

    task automatic check_all();
        chk("in_ready", umi_in_ready, exp_ready());
        for (int i = 0; i < M; i++) begin
            chk($sformatf("out_valid%0d", i), umi_out_valid[i], mq[i].size() != 0);
            if (mq[i].size() != 0)
                chk($sformatf("out_pkt%0d", i),
                    {umi_out_cmd[i*CW+:CW], umi_out_dstaddr[i*AW+:AW],
                     umi_out_srcaddr[i*AW+:AW], umi_out_data[i*DW+:DW]}, mq[i][0]);
        end
        chk("err_drop", err_drop, exp_err);
`ifdef UMI_DEMUX_PIPE_ERRCNT_EN
        chk("err_count", err_count, exp_cnt);
`endif
    endtask

    // One clock of checking plus model update; returns at posedge+1
    task automatic step();
        int           t;
        logic         acc;
        logic [M-1:0] pop;
        @(negedge clk);
        check_all();
        t   = tgt_of(umi_in_dstaddr);
        acc = umi_in_valid && exp_ready();
        for (int i = 0; i < M; i++) pop[i] = (mq[i].size() != 0) && umi_out_ready[i];
        @(posedge clk);
        if (exp_err && exp_cnt < 65535) exp_cnt++;
        for (int i = 0; i < M; i++) if (pop[i]) void'(mq[i].pop_front());
        if (acc && t >= 0) mq[t].push_back({umi_in_cmd, umi_in_dstaddr, umi_in_srcaddr, umi_in_data});
        exp_err  = acc && t < 0;
        last_acc = acc;
        #1;
    endtask

    task automatic load(input logic [M-1:0] sel);
        logic [AW-1:0] d;
        umi_in_cmd     = $urandom;
        d              = {$urandom, $urandom};
        d[SELLSB+:M]   = sel;
        umi_in_dstaddr = d;
        umi_in_srcaddr = {$urandom, $urandom};
        for (int k = 0; k < DW/32; k++) umi_in_data[k*32+:32] = $urandom;
        umi_in_valid   = 1'b1;
    endtask

    task automatic send(input logic [M-1:0] sel, input int maxcyc);
        load(sel);
        for (int k = 0; k < maxcyc; k++) begin
            step();
            if (last_acc) break;
        end
        if (!last_acc) begin
            n_cmp++; n_bad++;
            $display("FAIL send_timeout: sel %b not accepted within %0d cycles", sel, maxcyc);
        end
        umi_in_valid = 1'b0;
    endtask

    initial begin
        logic [PW-1:0] p1;
        int sent, cyc, vp, rp;

        // reset state
        #3;
        chk("rst_valid", umi_out_valid, 4'b0000);
        chk("rst_cmd", umi_out_cmd, '0);
        chk("rst_dst", umi_out_dstaddr, '0);
        chk("rst_src", umi_out_srcaddr, '0);
        chk("rst_data", umi_out_data, '0);
        chk("rst_err", err_drop, 1'b0);
        chk("rst_ready", umi_in_ready, 1'b1);
        @(negedge clk) nreset = 1'b1;
        @(posedge clk); #1;

        // single packet to port 2, visible exactly one cycle after accept
        load(4'b0100);
        p1 = {umi_in_cmd, umi_in_dstaddr, umi_in_srcaddr, umi_in_data};
        step();
        umi_in_valid = 1'b0;
        chk("t1_acc", last_acc, 1'b1);
        chk("t1_valid", umi_out_valid, 4'b0100);
        chk("t1_pkt", {umi_out_cmd[2*CW+:CW], umi_out_dstaddr[2*AW+:AW],
                       umi_out_srcaddr[2*AW+:AW], umi_out_data[2*DW+:DW]}, p1);
        chk("t1_err", err_drop, 1'b0);
        step();
        chk("t1_drained", umi_out_valid, 4'b0000);

        // port 1 stalled: third packet blocked, port 2 still flows
        umi_out_ready = 4'b1101;
        send(4'b0010, 4);
        send(4'b0010, 4);
        load(4'b0010);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t2_stall_acc", last_acc, 1'b0);
            chk("t2_stall_ready", umi_in_ready, 1'b0);
        end
        umi_out_ready[1] = 1'b1;
        step();
        umi_out_ready[1] = 1'b0;
        for (int k = 0; k < 4 && !last_acc; k++) step();
        chk("t2_third_acc", last_acc, 1'b1);
        umi_in_valid = 1'b0;
        send(4'b0100, 4);
        chk("t2_p2_valid", umi_out_valid[2], 1'b1);
        chk("t2_p1_held", umi_out_valid[1], 1'b1);
        step();
        umi_out_ready = '1;
        for (int k = 0; k < 4; k++) step();

        // invalid selects are consumed and dropped
        send(4'b0000, 1);
        chk("t3_err1", err_drop, 1'b1);
        send(4'b0110, 1);
        chk("t3_err2", err_drop, 1'b1);
        step();
        chk("t3_err_end", err_drop, 1'b0);
        chk("t3_no_valid", umi_out_valid, 4'b0000);
`ifdef UMI_DEMUX_PIPE_ERRCNT_EN
        chk("t3_count", err_count, 16'd2);
`endif
        step();

        // random traffic with varying valid/ready density
        sent = 0; vp = 50; rp = 50;
        for (cyc = 0; cyc < 30000 && sent < 1000; cyc++) begin
            if (cyc % 100 == 0) begin
                vp = $urandom_range(100, 10);
                rp = $urandom_range(100, 5);
            end
            if (!umi_in_valid && $urandom_range(99, 0) < vp)
                load(4'b0001 << $urandom_range(M-1, 0));
            for (int i = 0; i < M; i++) umi_out_ready[i] = ($urandom_range(99, 0) < rp);
            step();
            if (last_acc) begin
                sent++;
                umi_in_valid = 1'b0;
            end
        end
        chk("t4_sent", sent, 1000);
        umi_in_valid = 1'b0;
        umi_out_ready = '1;
        for (int k = 0; k < 4; k++) step();
        chk("t4_drained", umi_out_valid, 4'b0000);

        // async reset with ports 0 and 3 full
        umi_out_ready = 4'b0110;
        send(4'b0001, 4);
        send(4'b0001, 4);
        send(4'b1000, 4);
        send(4'b1000, 4);
        step();
        chk("t5_full", umi_out_valid, 4'b1001);
        #2 nreset = 1'b0;
        #1 chk("t5_rst_valid", umi_out_valid, 4'b0000);
        chk("t5_rst_ready", umi_in_ready, 1'b1);
        for (int i = 0; i < M; i++) mq[i].delete();
        exp_err = 1'b0;
        exp_cnt = 0;
        @(posedge clk);
        @(negedge clk) nreset = 1'b1;
        @(posedge clk); #1;
        umi_out_ready = '1;
        for (int k = 0; k < 3; k++) step();
        chk("t5_no_stale", umi_out_valid, 4'b0000);

`ifdef UMI_DEMUX_PIPE_ERRCNT_EN
        // counter saturation
        force dut.err_cnt_q = 16'hFFFE;
        exp_cnt = 65534;
        #1 release dut.err_cnt_q;
        send(4'b0000, 1);
        send(4'b0011, 1);
        send(4'b0000, 1);
        for (int k = 0; k < 3; k++) step();
        chk("t6_sat", err_count, 16'hFFFF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
